cmd_scheduler: RTL and testbench
================================

Name: cmd_scheduler

Overview:
Arbitrates game-command requests from several independent sources (UART keys, buttons, switches, gravity/bar timers) and queues them for the game engine. Fixed priority with an aging guard so the lowest-priority source (gravity tick) cannot starve. Buffers up to QSIZE commands and hands them to the engine over a valid/ready handshake; the engine asserts ready only while idle in its WAIT state. Sits between the input/timer front end and the game state machine.

Parameters:
NREQ, 4, number of requesters; index 0 is highest priority, index NREQ-1 is lowest and aged.
CMD_W, 4, command code width; code 0 is NONE.
QSIZE, 8, FIFO depth in commands (power of 2, >=2).
AGE_MAX, 3, consecutive lost arbitrations after which requester NREQ-1 is promoted to top priority.
COALESCE_CMD, 2, command code merged by the optional feature (engine DOWN code).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous queue clear (game start/over)
req_valid  in  NREQ  per-requester request
req_cmd  in  NREQ*CMD_W  per-requester code; slice i = [i*CMD_W +: CMD_W]
req_ready  out  NREQ  one-hot grant, combinational; transfer = valid & ready
out_valid  out  1  head of queue valid
out_cmd  out  CMD_W  head command; 0 when empty
out_ready  in  1  engine accepts head this cycle
occupancy  out  $clog2(QSIZE)+1  entries held

Behaviour:
- Reset (async, rst=1): FIFO empty, occupancy=0, out_valid=0, out_cmd=0, age counter=0. req_ready=0 while rst=1.
- Pop: when out_valid & out_ready, head removed at clock edge. out_cmd is registered head data, never X.
- Space: can_push = (occupancy < QSIZE) | (out_valid & out_ready). When !can_push or flush, req_ready=0.
- Arbitration (combinational, each cycle, when can_push & !flush): if req_valid[NREQ-1] and age==AGE_MAX, grant NREQ-1; else grant lowest index i with req_valid[i]. At most one req_ready bit high.
- Granted code 0: accepted (ready=1) and discarded, not pushed.
- Granted nonzero code: written at tail; visible at out_cmd the next cycle if queue was empty (1-cycle latency). No bypass.
- Push and pop same cycle: occupancy unchanged; legal even at full and at occupancy 1.
- Age counter: if req_valid[NREQ-1] & !req_ready[NREQ-1] & can_push & !flush, increments, saturating at AGE_MAX; cleared when NREQ-1 granted or req_valid[NREQ-1]=0. Held while blocked by full queue.
- flush: next edge empties FIFO, clears age; any pop in the same cycle is ignored. flush takes precedence over push and pop. Next cycle out_valid=0, out_cmd=0.
- Order: strict FIFO; pointers wrap modulo QSIZE; occupancy ranges 0..QSIZE.
- Requesters must hold req_valid and req_cmd stable until granted. Scheduler doesn't latch ungranted requests.

Optional Feature:
Macro CMD_SCHED_COALESCE_EN.
- Defined: a granted code equal to COALESCE_CMD is accepted but not pushed when the queue is nonempty and the current tail entry equals COALESCE_CMD (and that tail is not popped this cycle, or occupancy>1). Back-to-back gravity ticks collapse to one DOWN. Coalesced grant still counts as a grant for aging. Coalescing works even when full: ready=1 while can_push is 0.
- Undefined: every nonzero grant is pushed; no comparison logic.

Test Plan:
- Reset mid-run: occupancy=5, assert rst -> immediately out_valid=0, out_cmd=0, occupancy=0, req_ready=0; after release push code 7 -> out_cmd=7 one cycle later.
- Priority: req_valid=4'b1010 with codes 3 on idx1 and 5 on idx3 -> idx1 granted first; after it drops, idx3 granted; out order 3,5.
- Aging: idx0 held valid with code 4, idx3 held valid with code 2, out_ready=1 -> idx3 loses 3 cycles, granted on 4th; age then 0.
- Full/backpressure: out_ready=0, 8 pushes -> occupancy=8, req_ready=0; 9th push with out_ready=1 -> accepted same cycle, occupancy stays 8, FIFO order preserved.
- Flush collision: occupancy=3, flush=1 with req_valid and out_ready high -> no grant, next cycle occupancy=0, out_valid=0.
- COALESCE_EN on: tail=2, push 2 three times -> occupancy unchanged and ready=1 each time; push 6 -> occupancy+1. COALESCE_EN off: same stimulus adds 4 entries.

Source files
------------

// File: rtl/cmd_scheduler.sv
// -----------------------------------------------------------------------------
// cmd_scheduler
//
// Collects game-command requests from several independent sources and queues
// them for the game engine. Requester 0 has the highest priority. The lowest
// priority requester (NREQ-1, the gravity tick) carries an aging counter.
// After it loses AGE_MAX consecutive arbitrations it is promoted to the top.
// Accepted nonzero commands go into a QSIZE-deep FIFO. The FIFO head is
// offered to the engine over a valid/ready handshake.
//
// Ports:
//   clk        in   1            clock
//   rst        in   1            asynchronous active-high reset
//   flush      in   1            synchronous queue clear (game start/over)
//   req_valid  in   NREQ         per-requester request
//   req_cmd    in   NREQ*CMD_W   per-requester code, slice i = [i*CMD_W +: CMD_W]
//   req_ready  out  NREQ         one-hot grant (combinational)
//   out_valid  out  1            head of queue valid (registered)
//   out_cmd    out  CMD_W        head command, 0 when empty (registered)
//   out_ready  in   1            engine accepts head this cycle
//   occupancy  out  log2(QSIZE)+1 entries held (registered)
//
// Optional feature macro: CMD_SCHED_COALESCE_EN
//   When defined, a granted COALESCE_CMD is absorbed instead of pushed if the
//   current tail entry is already COALESCE_CMD and that tail survives this
//   cycle. This collapses back-to-back gravity ticks into a single DOWN.
// -----------------------------------------------------------------------------
module cmd_scheduler #(
    parameter int NREQ         = 4,
    parameter int CMD_W        = 4,
    parameter int QSIZE        = 8,
    parameter int AGE_MAX      = 3,
    parameter int COALESCE_CMD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*CMD_W-1:0]    req_cmd,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    output logic [CMD_W-1:0]         out_cmd,
    input  logic                     out_ready,
    output logic [$clog2(QSIZE):0]   occupancy
);

    localparam int PTR_W = $clog2(QSIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    // FIFO storage and state
    logic [CMD_W-1:0] mem_q [QSIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [CMD_W-1:0] out_cmd_q, out_cmd_d;
    logic [AGE_W-1:0] age_q, age_d;

    // Arbitration and handshake terms
    logic             win_found_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [CMD_W-1:0] win_cmd_s;
    logic             pop_s;
    logic             can_push_s;
    logic             coal_s;
    logic             grant_s;
    logic             push_s;

    // The engine takes the head only if there is one. A flush in the same
    // cycle overrides the pop.
    assign pop_s = out_valid_q & out_ready & ~flush;

    // A slot is free if the queue is not full or the head leaves this cycle.
    assign can_push_s = (count_q < CNT_W'(QSIZE)) | (out_valid_q & out_ready);

    // Pick the winner: an aged gravity tick first, otherwise the lowest
    // valid index.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        if (req_valid[NREQ-1] && (age_q == AGE_W'(AGE_MAX))) begin
            win_found_s = 1'b1;
            win_idx_s   = IDX_W'(NREQ - 1);
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                win_found_s = win_found_s | req_valid[i];
                win_idx_s   = req_valid[i] ? IDX_W'(i) : win_idx_s;
            end
        end
    end

    assign win_cmd_s = req_cmd[int'(win_idx_s)*CMD_W +: CMD_W];

`ifdef CMD_SCHED_COALESCE_EN
    logic [PTR_W-1:0] tail_ptr_s;
    assign tail_ptr_s = wr_ptr_q - PTR_W'(1);

    // Absorb a repeated DOWN only if the tail DOWN is not being popped out
    // from under us (occupancy 1 with the engine taking it).
    assign coal_s = (win_cmd_s == CMD_W'(COALESCE_CMD))
                  & (count_q != CNT_W'(0))
                  & (mem_q[tail_ptr_s] == CMD_W'(COALESCE_CMD))
                  & (~(out_valid_q & out_ready) | (count_q > CNT_W'(1)));
`else
    assign coal_s = 1'b0;
`endif

    // Coalescing never needs a slot, so it can be granted even while full.
    assign grant_s = win_found_s & ~rst & ~flush & (can_push_s | coal_s);

    // Code 0 (NONE) and absorbed DOWNs are acknowledged but not stored.
    assign push_s  = grant_s & (win_cmd_s != CMD_W'(0)) & ~coal_s;

    // Decode the one-hot grant back to the requesters.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = grant_s & (win_idx_s == IDX_W'(i));
        end
    end

    // Compute the next pointers and count. A flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Compute the next registered head. If the queue drains this cycle while
    // a push happens, the new entry becomes the head directly. Otherwise the
    // head is an entry already in storage.
    always_comb begin
        out_valid_d = (count_d != CNT_W'(0));
        if (flush || (count_d == CNT_W'(0))) begin
            out_cmd_d = '0;
        end else if (push_s && (count_q == CNT_W'(pop_s))) begin
            out_cmd_d = win_cmd_s;
        end else begin
            out_cmd_d = mem_q[rd_ptr_d];
        end
    end

    // Compute the next age of the gravity requester. The counter is held
    // while a full queue blocks everyone, because no arbitration was lost.
    always_comb begin
        if (flush || !req_valid[NREQ-1] || req_ready[NREQ-1]) begin
            age_d = '0;
        end else if (can_push_s && (age_q != AGE_W'(AGE_MAX))) begin
            age_d = age_q + AGE_W'(1);
        end else begin
            age_d = age_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_cmd_q   <= '0;
            age_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
            age_q       <= age_d;
        end
    end

    // FIFO storage. It has no reset because only written slots are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= win_cmd_s;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cmd   = out_cmd_q;
    assign occupancy = count_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
module tb_cmd_scheduler;

    localparam int NREQ = 4, CMD_W = 4, QSIZE = 8, AGE_MAX = 3, COALESCE_CMD = 2;
    localparam int OCC_W = $clog2(QSIZE) + 1;

    logic                  clk = 1'b0;
    logic                  rst, flush, out_ready;
    logic [NREQ-1:0]       req_valid, req_ready;
    logic [NREQ*CMD_W-1:0] req_cmd;
    logic                  out_valid;
    logic [CMD_W-1:0]      out_cmd;
    logic [OCC_W-1:0]      occupancy;

    int checks = 0;
    int failures = 0;

    // Reference model: a plain queue of pending commands plus the gravity age.
    int q[$];
    int age = 0;
    logic [NREQ-1:0] exp_ready = '0;

    always #5 clk = ~clk;

    cmd_scheduler #(.NREQ(NREQ), .CMD_W(CMD_W), .QSIZE(QSIZE),
                    .AGE_MAX(AGE_MAX), .COALESCE_CMD(COALESCE_CMD)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .out_valid(out_valid), .out_cmd(out_cmd), .out_ready(out_ready),
        .occupancy(occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cmd_of(input int i);
        return int'(req_cmd[i*CMD_W +: CMD_W]);
    endfunction

    function automatic bit coal_hit(input int w);
`ifdef CMD_SCHED_COALESCE_EN
        return (cmd_of(w) == COALESCE_CMD) && (q.size() > 0) && (q[$] == COALESCE_CMD)
               && !(q.size() == 1 && out_ready);
`else
        return (w < 0);
`endif
    endfunction

    // Expected grant for the current inputs, from the arbitration rules.
    task automatic model_expect(output bit can_push, output int win, output bit coal);
        int occ;
        occ = q.size();
        can_push = (occ < QSIZE) || (occ > 0 && out_ready);
        win = -1;
        coal = 1'b0;
        if (req_valid[NREQ-1] && age == AGE_MAX) win = NREQ - 1;
        else for (int i = NREQ - 1; i >= 0; i--) if (req_valid[i]) win = i;
        exp_ready = '0;
        if (!rst && !flush && win >= 0) begin
            coal = coal_hit(win);
            if (can_push || coal) exp_ready[win] = 1'b1;
        end
    endtask

    // Check all outputs against the model, advance the model, then cross one edge.
    task automatic tick(input string tag);
        bit cp, cl;
        int w, occ;
        #2;
        model_expect(cp, w, cl);
        occ = q.size();
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_ready));
        chk({tag, ".valid"}, 32'(out_valid), 32'(occ > 0));
        chk({tag, ".cmd"},   32'(out_cmd),   (occ > 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".occ"},   32'(occupancy), 32'(occ));
        if (rst || flush) begin
            q.delete();
            age = 0;
        end else begin
            if (occ > 0 && out_ready) void'(q.pop_front());
            if (exp_ready != '0 && !cl && cmd_of(w) != 0) q.push_back(cmd_of(w));
            if (!req_valid[NREQ-1] || exp_ready[NREQ-1]) age = 0;
            else if (cp && age < AGE_MAX) age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input int c);
        req_cmd[i*CMD_W +: CMD_W] = CMD_W'(c);
    endtask

    task automatic push0(input int c, input string tag);
        req_valid = 4'b0001;
        set_cmd(0, c);
        tick(tag);
    endtask

    // A granted requester may raise a new request. An ungranted one holds.
    task automatic rand_req();
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || exp_ready[i]) begin
                req_valid[i] = ($urandom_range(0, 2) != 0);
                set_cmd(i, int'($urandom_range(0, 15)));
            end
        end
        out_ready = $urandom_range(0, 1) != 0;
        flush = ($urandom_range(0, 29) == 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; req_valid = '0; req_cmd = '0;
        #1;
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.occ", 32'(occupancy), 32'd0);
        tick("reset");
        rst = 1'b0;
        tick("idle");

        // Priority: idx1 (code 3) beats idx3 (code 5).
        req_cmd = {4'd5, 4'd0, 4'd3, 4'd0};
        req_valid = 4'b1010;
        #1 chk("prio.idx1", 32'(req_ready), 32'b0010);
        tick("prio1");
        req_valid = 4'b1000;
        #1 chk("prio.idx3", 32'(req_ready), 32'b1000);
        tick("prio2");
        req_valid = '0; out_ready = 1'b1;
        #1 chk("prio.first", 32'(out_cmd), 32'd3);
        tick("prio3");
        #1 chk("prio.second", 32'(out_cmd), 32'd5);
        tick("prio4");
        tick("prio5");

        // Aging: idx3 loses three times, wins on the fourth, then starts over.
        req_cmd = {4'd2, 4'd0, 4'd0, 4'd4};
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1 chk("age.lose", 32'(req_ready), 32'b0001);
            tick("age");
        end
        #1 chk("age.win", 32'(req_ready), 32'b1000);
        tick("age.win");
        #1 chk("age.reset", 32'(req_ready), 32'b0001);
        tick("age.after");
        req_valid = '0;
        tick("age.d1");
        tick("age.d2");

        // Full / backpressure.
        out_ready = 1'b0;
        for (int i = 0; i < QSIZE; i++) push0(i + 1, "fill");
        set_cmd(0, 9);
        #1 chk("full.occ", 32'(occupancy), 32'd8);
        chk("full.ready", 32'(req_ready), 32'd0);
        tick("full.block");
        out_ready = 1'b1;
        #1 chk("full.pushpop", 32'(req_ready), 32'b0001);
        tick("full.pp");
        #1 chk("full.occ2", 32'(occupancy), 32'd8);
        chk("full.head", 32'(out_cmd), 32'd2);
        req_valid = '0;
        for (int i = 0; i < QSIZE + 1; i++) tick("drain");

        // Flush colliding with a request and a pop.
        out_ready = 1'b0;
        push0(10, "fl"); push0(11, "fl"); push0(12, "fl");
        set_cmd(0, 13);
        flush = 1'b1; out_ready = 1'b1;
        #1 chk("flush.ready", 32'(req_ready), 32'd0);
        tick("flush");
        flush = 1'b0; req_valid = '0;
        #1 chk("flush.occ", 32'(occupancy), 32'd0);
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.cmd", 32'(out_cmd), 32'd0);
        tick("flush.after");

        // Repeated DOWN codes behind a DOWN tail.
        out_ready = 1'b0;
        push0(2, "co.first");
        for (int k = 0; k < 3; k++) begin
            #1 chk("co.ready", 32'(req_ready), 32'b0001);
            tick("co.dup");
        end
        push0(6, "co.six");
        req_valid = '0;
`ifdef CMD_SCHED_COALESCE_EN
        #1 chk("co.occ", 32'(occupancy), 32'd2);
`else
        #1 chk("co.occ", 32'(occupancy), 32'd5);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick("co.drain");

        // Reset in the middle of a run.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push0(i + 1, "mr.fill");
        set_cmd(0, 3);
        #2 rst = 1'b1;
        #1 chk("mr.valid", 32'(out_valid), 32'd0);
        chk("mr.cmd", 32'(out_cmd), 32'd0);
        chk("mr.occ", 32'(occupancy), 32'd0);
        chk("mr.ready", 32'(req_ready), 32'd0);
        q.delete(); age = 0;
        tick("mr.rst");
        rst = 1'b0;
        push0(7, "mr.push");
        req_valid = '0;
        #1 chk("mr.cmd7", 32'(out_cmd), 32'd7);
        tick("mr.after");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rand_req();
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
